// File: rtl/dmem_block_mover.sv
// dmem_block_mover: clear/fill/copy engine for a single-port word-addressed data memory
module dmem_block_mover #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] pattern,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_din,
  output logic              m_store,
  output logic              m_load,
  input  logic [DATA_W-1:0] m_dout
);
  typedef enum logic [2:0] {IDLE, FILL, RD, WR, DONE} state_t;
  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   sp_q, sp_d, dp_q, dp_d, sp_nx, dp_nx;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   pat_q, pat_d, data_q, data_d;
  logic                dec_q, dec_d, last;
  logic [ADDR_W-1:0]   len_lo;
  assign len_lo = len[ADDR_W-1:0];
  assign sp_nx  = dec_q ? sp_q - ADDR_W'(1) : sp_q + ADDR_W'(1);
  assign dp_nx  = dec_q ? dp_q - ADDR_W'(1) : dp_q + ADDR_W'(1);
  assign last   = cnt_q == (ADDR_W+1)'(1);
  // Next-state and memory-port decode; descending copies start at the top word so overlap is safe
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sp_d    = sp_q;
    dp_d    = dp_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    data_d  = data_q;
    dec_d   = dec_q;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    m_store = 1'b0;
    m_load  = 1'b0;
    m_addr  = '0;
    m_din   = '0;
    case (state_q)
      IDLE: if (start) begin
        op_d    = op;
        pat_d   = pattern;
        cnt_d   = len;
        dec_d   = (op == 2'd2) && (dst > src);
        sp_d    = dec_d ? src + len_lo - ADDR_W'(1) : src;
        dp_d    = dec_d ? dst + len_lo - ADDR_W'(1) : dst;
        state_d = (len == '0 || op == 2'd3) ? DONE : (op == 2'd2) ? RD : FILL;
      end
      FILL: begin
        busy    = 1'b1;
        m_store = 1'b1;
        m_addr  = dp_q;
        m_din   = (op_q == 2'd0) ? '0 : pat_q;
        dp_d    = dp_nx;
        cnt_d   = cnt_q - (ADDR_W+1)'(1);
        state_d = last ? DONE : FILL;
      end
      RD: begin
        busy    = 1'b1;
        m_load  = 1'b1;
        m_addr  = sp_q;
        data_d  = m_dout;
        sp_d    = sp_nx;
        state_d = WR;
      end
      WR: begin
        busy    = 1'b1;
        m_store = 1'b1;
        m_addr  = dp_q;
        m_din   = data_q;
        dp_d    = dp_nx;
        cnt_d   = cnt_q - (ADDR_W+1)'(1);
        state_d = last ? DONE : RD;
      end
      DONE: begin
        done    = 1'b1;
        err     = op_q == 2'd3;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers; clr aborts any command immediately
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      op_q    <= '0;
      sp_q    <= '0;
      dp_q    <= '0;
      cnt_q   <= '0;
      pat_q   <= '0;
      data_q  <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sp_q    <= sp_d;
      dp_q    <= dp_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      data_q  <= data_d;
      dec_q   <= dec_d;
    end
  end
endmodule

// File: tb/tb_dmem_block_mover.sv
// tb_dmem_block_mover: randomized scoreboard bench with a memmove-style reference model
module tb_dmem_block_mover;
  localparam int AW = 10;
  localparam int DW = 32;
  typedef struct packed {logic st; logic [AW-1:0] a; logic [DW-1:0] d;} acc_t;
  logic clk = 1'b0, clr = 1'b1, start = 1'b0;
  logic [1:0] op = '0;
  logic [AW-1:0] src = '0, dst = '0;
  logic [AW:0] len = '0;
  logic [DW-1:0] pattern = '0;
  logic busy, done, err, m_store, m_load;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din, m_dout;
  logic pk_en = 1'b0;
  logic [AW-1:0] pk_a = '0;
  logic [DW-1:0] pk_d = '0;
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] ref_mem [1024];
  acc_t exp_q[$];
  logic done_q[$];
  int checks = 0, errors = 0, busy_n = 0;
  dmem_block_mover #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .src(src), .dst(dst), .len(len),
    .pattern(pattern), .busy(busy), .done(done), .err(err), .m_addr(m_addr),
    .m_din(m_din), .m_store(m_store), .m_load(m_load), .m_dout(m_dout)
  );
  always #5 clk = ~clk;
  assign m_dout = mem[m_addr];
  always @(posedge clk) begin
    if (pk_en) mem[pk_a] <= pk_d;
    if (m_store) mem[m_addr] <= m_din;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, expv, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!clr) begin
      if (busy) busy_n++;
      chk("busy_vs_access", busy, m_store | m_load);
      chk("strobe_exclusive", m_store & m_load, 0);
      if (!m_store && !m_load) chk("quiet_bus", {m_addr, m_din}, 0);
      else if (exp_q.size() == 0) chk("unexpected_access", {m_store, m_addr}, 0);
      else begin
        acc_t e;
        e = exp_q.pop_front();
        chk("access_kind", m_store, e.st);
        chk("access_addr", m_addr, e.a);
        if (m_store) chk("store_data", m_din, e.d);
      end
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_err", err, done_q.pop_front());
      end else chk("err_without_done", err, 0);
    end
  end
  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pk_en = 1'b1; pk_a = a; pk_d = d; ref_mem[a] = d;
    @(negedge clk);
    pk_en = 1'b0;
  endtask
  task automatic model(input logic [1:0] o, input logic [AW-1:0] s, input logic [AW-1:0] d,
                       input int n, input logic [DW-1:0] p, input int lim);
    int left, i;
    logic [AW-1:0] sa, da;
    logic [DW-1:0] w;
    left = lim;
    if (o == 2'd3 || n == 0) begin
      done_q.push_back(o == 2'd3);
      return;
    end
    for (int k = 0; k < n; k++) begin
      i = (o == 2'd2 && d > s) ? n - 1 - k : k;
      sa = AW'(int'(s) + i);
      da = AW'(int'(d) + i);
      if (o == 2'd2) begin
        if (left == 0) return;
        left--;
        exp_q.push_back('{1'b0, sa, '0});
        w = ref_mem[sa];
      end else w = (o == 2'd0) ? '0 : p;
      if (left == 0) return;
      left--;
      exp_q.push_back('{1'b1, da, w});
      ref_mem[da] = w;
    end
    done_q.push_back(1'b0);
  endtask
  task automatic mem_compare();
    int nbad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) nbad++;
    chk("mem_mismatch_words", nbad, 0);
  endtask
  task automatic issue(input logic [1:0] o, input logic [AW-1:0] s, input logic [AW-1:0] d,
                       input int n, input logic [DW-1:0] p, input bit noise);
    int cyc, b0, eb;
    cyc = 0;
    b0 = busy_n;
    eb = (o == 2'd3 || n == 0) ? 0 : (o == 2'd2) ? 2 * n : n;
    model(o, s, d, n, p, 1 << 30);
    op = o; src = s; dst = d; len = (AW+1)'(n); pattern = p; start = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      start = noise && cyc == 2;
      op = 2'($urandom); src = AW'($urandom); dst = AW'($urandom);
      len = (AW+1)'($urandom); pattern = $urandom;
      if (done || cyc > 2100) break;
    end
    start = 1'b0;
    chk("timeout", cyc > 2100, 0);
    chk("cycles_to_done", cyc, eb + 1);
    chk("busy_cycles", busy_n - b0, eb);
    @(negedge clk);
    chk("pending_expected", exp_q.size() + done_q.size(), 0);
    mem_compare();
  endtask
  initial begin
    logic [DW-1:0] old;
    logic [1:0] ro;
    logic [AW-1:0] rs, rd;
    int rn;
    #1 chk("reset_outputs", {busy, done, err, m_store, m_load, m_addr, m_din}, 0);
    @(negedge clk);
    for (int i = 0; i < 1024; i++) poke(AW'(i), $urandom);
    clr = 1'b0;
    @(negedge clk);
    issue(2'd0, '0, 10'h3FE, 4, 32'h12345678, 1'b0);
    issue(2'd1, '0, 10'h010, 3, 32'hDEADBEEF, 1'b0);
    poke(10'h000, 32'h11); poke(10'h001, 32'h22);
    issue(2'd2, 10'h000, 10'h100, 2, '0, 1'b0);
    poke(10'h020, 32'hAAAA); poke(10'h021, 32'hBBBB); poke(10'h022, 32'hCCCC);
    issue(2'd2, 10'h020, 10'h021, 3, '0, 1'b0);
    issue(2'd0, 10'h005, 10'h006, 0, '0, 1'b0);
    issue(2'd3, 10'h001, 10'h002, 5, '0, 1'b0);
    issue(2'd1, '0, 10'h040, 8, 32'hCAFEF00D, 1'b1);
    issue(2'd2, 10'h3FE, 10'h3FF, 4, '0, 1'b1);
    issue(2'd1, '0, 10'h123, 1024, 32'h5A5A5A5A, 1'b0);
    for (int i = 0; i < 4; i++) poke(AW'(10'h200 + i), $urandom);
    old = ref_mem[10'h301];
    model(2'd2, 10'h200, 10'h300, 3, '0, 4);
    op = 2'd2; src = 10'h200; dst = 10'h300; len = 11'd3; start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("second_wr_before_clr", {m_store, m_addr}, {1'b1, 10'h301});
    #2 clr = 1'b1;
    #1 chk("abort_outputs", {busy, done, err, m_store, m_load, m_addr, m_din}, 0);
    ref_mem[10'h301] = old;
    repeat (2) begin
      @(posedge clk);
      #1 chk("no_done_in_reset", {done, m_store}, 0);
    end
    @(negedge clk);
    chk("pending_after_abort", exp_q.size() + done_q.size(), 0);
    clr = 1'b0;
    issue(2'd0, '0, 10'h300, 6, '0, 1'b0);
    for (int t = 0; t < 40; t++) begin
      ro = 2'($urandom_range(0, 3));
      rs = AW'($urandom);
      rd = ($urandom_range(0, 1) == 1) ? AW'(int'(rs) + $urandom_range(0, 4) - 2) : AW'($urandom);
      rn = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 300) : $urandom_range(0, 12);
      issue(ro, rs, rd, rn, $urandom, (ro != 2'd3) && rn >= 4 && ($urandom_range(0, 1) == 1));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_block_mover.md
DMEM_BLOCK_MOVER -- requirements
Module: dmem_block_mover

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, giving the width of the data-memory word address.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the width of a data-memory word.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port clr, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: command request, sampled only in IDLE.
REQ-006 The block SHALL have port op, input, 2 bits: command code, where 0 = clear, 1 = fill, 2 = copy, and 3 = reserved.
REQ-007 The block SHALL have port src, input, ADDR_W bits: copy source base address.
REQ-008 The block SHALL have port dst, input, ADDR_W bits: destination base address.
REQ-009 The block SHALL have port len, input, ADDR_W+1 bits: word count, valid range 0..1024.
REQ-010 The block SHALL have port pattern, input, DATA_W bits: fill word.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a command is executing.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port err, output, 1 bit: one-cycle pulse, coincident with done, for a reserved op.
REQ-014 The block SHALL have port m_addr, output, ADDR_W bits: memory word address.
REQ-015 The block SHALL have port m_din, output, DATA_W bits: memory write data.
REQ-016 The block SHALL have ports m_store and m_load, outputs, 1 bit each: memory write strobe and read strobe.
REQ-017 The block SHALL have port m_dout, input, DATA_W bits: memory read data, valid combinationally in the same cycle as m_load and m_addr.

Function
REQ-018 The FSM SHALL have exactly five states: IDLE, FILL, RD, WR, DONE.
REQ-019 In IDLE, start=1 at a rising edge SHALL latch op, src, dst, len and pattern, and SHALL select the next state as follows:
- DONE if len=0 or op=3;
- FILL if op is 0 or 1;
- RD if op=2.
REQ-020 In FILL, the block SHALL assert m_store=1 and m_addr=current dst pointer.
- m_din SHALL be 0 for clear and the latched pattern for fill.
- The block SHALL advance one word per cycle, giving exactly len consecutive store cycles.
REQ-021 In RD, the block SHALL assert m_load=1 and m_addr=current src pointer, and SHALL register m_dout into a data register at the clock edge.
REQ-022 In WR, the block SHALL assert m_store=1, m_addr=current dst pointer and m_din=data register.
- A copy SHALL alternate RD and WR, taking 2*len cycles.
REQ-023 Copy direction SHALL be descending when latched dst > src, otherwise ascending.
- In descending mode, the pointers SHALL start at src+len-1 and dst+len-1 (mod 2^ADDR_W) and decrement.
- The result SHALL be correct for overlapping regions.
REQ-024 All pointer arithmetic SHALL wrap modulo 2^ADDR_W, so 0x3FF+1 = 0x000 and 0x000-1 = 0x3FF.
REQ-025 A remaining-count register SHALL decrement per word written; after the last write, the next state SHALL be DONE.
REQ-026 In DONE, the block SHALL assert done=1 for exactly one cycle (err=1 too if op=3), then return to IDLE.
REQ-027 busy SHALL be 1 in FILL, RD and WR, and 0 in IDLE and DONE.
REQ-028 start SHALL be ignored in every state except IDLE, and command inputs SHALL be ignored after latching.
REQ-029 m_store and m_load SHALL never be high simultaneously, and both SHALL be 0 in IDLE and DONE.
REQ-030 When m_store=0 and m_load=0, m_addr and m_din SHALL be 0.
REQ-031 Latency: a start accepted at edge k SHALL produce its first memory access in the cycle after edge k.

Reset
REQ-032 clr=1 SHALL immediately, without waiting for clk, force the state to IDLE and clear all pointers, counters and the data register.
- busy, done, err, m_store, m_load, m_addr and m_din SHALL all read 0.
REQ-033 A reset mid-command SHALL abort the command with no further stores, and SHALL produce no done pulse.
REQ-034 After clr deasserts, a start in the first IDLE cycle SHALL be accepted normally.

Verification
REQ-035 Clear with wrap: op=0, dst=0x3FE, len=4 -> 4 consecutive m_store cycles at 0x3FE, 0x3FF, 0x000, 0x001 with m_din=0, then done for 1 cycle.
REQ-036 Fill: op=1, dst=0x010, len=3, pattern=0xDEADBEEF -> addresses 0x010..0x012 hold 0xDEADBEEF, busy high for exactly 3 cycles.
REQ-037 Ascending copy: mem[0x000]=0x11, mem[0x001]=0x22, op=2, src=0x000, dst=0x100, len=2 -> sequence RD 0x000, WR 0x100, RD 0x001, WR 0x101, giving mem[0x100..0x101]=0x11, 0x22 after 4 busy cycles.
REQ-038 Overlapping copy: mem[0x020..0x022]=A, B, C, src=0x020, dst=0x021, len=3 -> order RD 0x022/WR 0x023, RD 0x021/WR 0x022, RD 0x020/WR 0x021, giving final mem[0x020..0x023]=A, A, B, C.
REQ-039 Degenerate commands:
- len=0, op=0 -> done on the cycle after acceptance, no store;
- op=3, len=5 -> done=1 and err=1 together, no memory access;
- start while busy -> ignored.
REQ-040 Reset mid-copy: assert clr during the second WR -> all outputs 0 at once, no done pulse; a following clear command completes correctly.
